// File: rtl/branch_sequencer_pkg.sv
// branch_sequencer_pkg: shared definitions for the fetch-side branch sequencer.
//   op_code     - instruction opcodes seen by the sequencer (NOP, CBF/CBB braces, others)
//   core_state  - processor state register encoding
//   STALL_CYCLES_DEF, STALL_CNT_W - stall bubble default length and counter width
package branch_sequencer_pkg;

  typedef enum logic [3:0] {
    NOP  = 4'h0,
    INC  = 4'h1,
    DEC  = 4'h2,
    MVR  = 4'h3,
    MVL  = 4'h4,
    PUSH = 4'h5,
    POP  = 4'h6,
    OUTP = 4'h7,
    INP  = 4'h8,
    CBF  = 4'h9,
    CBB  = 4'hA
  } op_code;

  typedef enum logic [1:0] {
    CORE_S   = 2'd0,
    BRANCH_S = 2'd1,
    STALL_S  = 2'd2
  } core_state;

  localparam int STALL_CYCLES_DEF = 1;
  localparam int STALL_CNT_W      = 4;

endpackage

// File: rtl/branch_sequencer_depth.sv
// brace_depth_counter: saturating up/down nesting-depth counter.
//   clk, rst_n  - clock, async active-low reset
//   clr         - synchronous clear to zero (highest priority)
//   inc, dec    - count up / down; inc wins if both are set
//   depth       - current count, saturates at all-ones and holds at zero
//   ovf         - sticky, set on an increment attempted at all-ones; cleared only by reset
module brace_depth_counter #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic               dec,
  output logic [DEPTH_W-1:0] depth,
  output logic               ovf
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      depth <= '0;
    end else if (inc) begin
      if (depth == '1) ovf <= 1'b1;
      else             depth <= depth + 1'b1;
    end else if (dec) begin
      if (depth != '0) depth <= depth - 1'b1;
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: holds the core state register and gates the opcode to the decoder.
//   clk, rst_n        - core clock, async active-low reset
//   instr_in          - opcode at current PC
//   fetch_valid       - instr_in valid this cycle; all registers hold when low
//   ctrl_state        - next state requested by the decoder (used in CORE_S only)
//   ctrl_pc_write     - PC write requested by the decoder (used in CORE_S only)
//   instr_out         - opcode to decoder, NOP whenever not executing
//   state             - current registered state
//   pc_write          - PC advance enable
//   depth, depth_ovf  - skip nesting depth and its sticky overflow flag
//   skip_count        - saturating count of valid BRANCH_S cycles (BEEF_BRANCH_STATS_EN only)
// Optional feature macro: BEEF_BRANCH_STATS_EN
//
// state    | meaning
// CORE_S   | executing: opcode passes straight to the decoder
// BRANCH_S | skipping forward to the matching CBB, tracking brace depth
// STALL_S  | bubble of STALL_CYCLES clocks, then re-present the opcode at PC
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int DEPTH_W      = 8,
  parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  op_code             instr_in,
  input  logic               fetch_valid,
  input  core_state          ctrl_state,
  input  logic               ctrl_pc_write,
  output op_code             instr_out,
  output core_state          state,
  output logic               pc_write,
  output logic [DEPTH_W-1:0] depth,
  output logic               depth_ovf
`ifdef BEEF_BRANCH_STATS_EN
  ,
  output logic [15:0]        skip_count
`endif
);

  localparam logic [STALL_CNT_W-1:0] STALL_LOAD = STALL_CNT_W'(STALL_CYCLES - 1);

  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   depth_clr;
  logic                   depth_inc;
  logic                   depth_dec;

  // rst_n gates the outputs so nothing leaks to the decoder while reset is held.
  always_comb begin
    instr_out = NOP;
    pc_write  = 1'b0;
    depth_clr = 1'b0;
    depth_inc = 1'b0;
    depth_dec = 1'b0;
    if (rst_n && fetch_valid) begin
      case (state)
        CORE_S: begin
          instr_out = instr_in;
          pc_write  = ctrl_pc_write;
          depth_clr = (ctrl_state == BRANCH_S);
        end
        BRANCH_S: begin
          pc_write  = 1'b1;
          depth_inc = (instr_in == CBF);
          // depth==0 on CBB is the exit, never a decrement
          depth_dec = (instr_in == CBB) && (depth != '0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CORE_S;
      stall_cnt <= '0;
    end else begin
      case (state)
        CORE_S: begin
          if (fetch_valid) begin
            case (ctrl_state)
              BRANCH_S: state <= BRANCH_S;
              STALL_S: begin
                state     <= STALL_S;
                stall_cnt <= STALL_LOAD;
              end
              default:  state <= CORE_S;
            endcase
          end
        end
        BRANCH_S: begin
          if (fetch_valid && (instr_in == CBB) && (depth == '0)) state <= CORE_S;
        end
        STALL_S: begin
          if (fetch_valid) begin
            if (stall_cnt == '0) state <= CORE_S;
            else                 stall_cnt <= stall_cnt - 1'b1;
          end
        end
        default: state <= CORE_S;
      endcase
    end
  end

  brace_depth_counter #(.DEPTH_W(DEPTH_W)) u_depth (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (depth_clr),
    .inc   (depth_inc),
    .dec   (depth_dec),
    .depth (depth),
    .ovf   (depth_ovf)
  );

`ifdef BEEF_BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_count <= '0;
    end else if (fetch_valid && (state == BRANCH_S) && (skip_count != 16'hFFFF)) begin
      skip_count <= skip_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Fetch-side sequencer between instruction memory and the core control decoder. Holds the processor state register (CORE_S / BRANCH_S / STALL_S) and gates the opcode presented to the decoder. In BRANCH_S it scans forward past a not-taken CBF to the matching CBB with a nesting-depth counter. STALL_S inserts a programmable bubble for multi-cycle ops (POP, taken CBF/CBB).

## Interface
- DEPTH_W, 8: width of brace nesting-depth counter.
- STALL_CYCLES, 1: bubble length of STALL_S, range 1..15.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- instr_in  in  op_code  opcode at current PC from instruction memory.
- fetch_valid  in  1  instr_in valid this cycle.
- ctrl_state  in  core_state  next state requested by the decoder bundle.
- ctrl_pc_write  in  1  PC write requested by the decoder bundle.
- instr_out  out  op_code  opcode to decoder; NOP whenever not executing.
- state  out  core_state  current registered state.
- pc_write  out  1  PC advance enable to the PC register.
- depth  out  DEPTH_W  current skip nesting depth.
- depth_ovf  out  1  sticky, set on nesting overflow.
- skip_count  out  16  present only with BEEF_BRANCH_STATS_EN.

## Operation
- Reset (async, rst_n low): state=CORE_S, depth=0, stall counter=0, depth_ovf=0, skip_count=0. While rst_n is low, instr_out=NOP and pc_write=0 regardless of inputs.
- fetch_valid=0 in any state: instr_out=NOP, pc_write=0, all registers hold.
- CORE_S: instr_out=instr_in, pc_write=ctrl_pc_write. Next state=ctrl_state.
  - Entering BRANCH_S clears depth to 0. The opening CBF is already consumed.
  - Entering STALL_S loads the stall counter with STALL_CYCLES-1.
- BRANCH_S: instr_out=NOP and pc_write=1 on each valid cycle.
  - CBF: depth+1. At depth=all-ones, depth saturates and depth_ovf sets.
  - CBB with depth>0: depth-1.
  - CBB with depth=0: next state=CORE_S. The matching CBB is skipped and the PC advances past it.
  - All other opcodes: depth holds.
  - ctrl_state is ignored.
- STALL_S: instr_out=NOP, pc_write=0.
  - Counter=0: next state=CORE_S.
  - Otherwise: counter decrements.
  - The instruction at PC is re-presented to the decoder on return to CORE_S. The decoder owns the second-phase behaviour.
- An illegal state encoding recovers to CORE_S on the next clock.
- depth_ovf clears only on reset.

## Timing
- State, depth and counter registers update on the rising edge of clk. instr_out and pc_write are combinational from the registered state and current inputs.
- Zero-latency pass-through in CORE_S.
- A CBF not-taken at cycle N puts the block in BRANCH_S at N+1.
- Skipping k instructions plus the matching CBB takes k+1 valid cycles. CORE_S resumes on the cycle after the matching CBB.
- STALL_S lasts exactly STALL_CYCLES clocks with fetch_valid held high.
- A depth decrement and the exit condition are never simultaneous. Exit requires depth=0 before the edge.
- Reset asserted mid-branch or mid-stall: return to CORE_S immediately. Partial depth is discarded.

## Configuration
- BEEF_BRANCH_STATS_EN defined:
  - adds the skip_count port and a 16-bit counter;
  - the counter increments on every valid BRANCH_S cycle, including the matching CBB;
  - it saturates at 16'hFFFF and clears only on reset.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- The definitions package supplies op_code (including NOP and CBF/CBB) and core_state (CORE_S, BRANCH_S, STALL_S).
- New package constants: STALL_CYCLES default and STALL_CNT_W=4.
- One sub-module, brace_depth_counter: a saturating up/down counter with clear and a sticky overflow flag, parameterised by DEPTH_W.
- The state machine stays in branch_sequencer.

## Test plan
- Reset: pulse rst_n low mid-BRANCH_S at depth=3 -> state=CORE_S, depth=0, instr_out=NOP, pc_write=0 during reset.
- Pass-through: CORE_S, instr_in=INC, ctrl_state=CORE_S, ctrl_pc_write=1 -> instr_out=INC, pc_write=1 same cycle.
- Nested skip: enter BRANCH_S, then feed INC, CBF, DEC, CBB, MVR, CBB -> depth goes 0,1,1,0,0. CORE_S after the final CBB, 6 cycles with pc_write=1 and instr_out=NOP; skip_count=6 when stats are enabled.
- Stall: STALL_CYCLES=3, ctrl_state=STALL_S on POP -> 3 cycles of NOP with pc_write=0, then instr_out=POP re-presented in CORE_S.
- Fetch gaps: BRANCH_S with fetch_valid toggling 1,0,1 over CBF, x, CBB -> depth 1 then 0, held during the gap, no pc_write in the gap.
- Overflow: DEPTH_W=2, four consecutive CBFs in BRANCH_S -> depth saturates at 3 and depth_ovf=1, still set after a later return to CORE_S.
